// File: rtl/vga_pkg.sv
// vga_pkg: shared timing constants for the VGA timing generator and a helper
// that sums the four segments of one axis into its total length.
package vga_pkg;

    // Segment lengths of one axis (horizontal in pixels, vertical in lines).
    typedef struct packed {
        logic [15:0] visible;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } axis_timing_t;

    // 800x600@60, 40 MHz pixel clock, positive syncs.
    localparam int           SVGA_PIX_HZ = 40_000_000;
    localparam axis_timing_t SVGA_H      = '{16'd800, 16'd40, 16'd128, 16'd88};
    localparam axis_timing_t SVGA_V      = '{16'd600, 16'd1, 16'd4, 16'd23};
    localparam bit           SVGA_POL    = 1'b1;

    // 640x480@60, 25 MHz pixel clock (nominally 25.175), negative syncs.
    localparam int           VGA_PIX_HZ  = 25_000_000;
    localparam axis_timing_t VGA_H       = '{16'd640, 16'd16, 16'd96, 16'd48};
    localparam axis_timing_t VGA_V       = '{16'd480, 16'd10, 16'd2, 16'd33};
    localparam bit           VGA_POL     = 1'b0;

    function automatic int axis_total(input int visible, input int fp,
                                      input int sync, input int bp);
        return visible + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis. Counts 0..TOTAL-1 on each step and
// decodes the visible and sync regions from the current position.
module vga_axis_counter #(
    parameter int COUNT_W = 12,
    parameter int VISIBLE = 800,
    parameter int FP      = 40,
    parameter int SYNC    = 128,
    parameter int BP      = 88
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step,
    output logic [COUNT_W-1:0] pos,
    output logic               wrap,
    output logic               active,
    output logic               sync_on
);
    import vga_pkg::*;

    // One spare bit so a region end equal to 2^COUNT_W still compares correctly.
    localparam int XW    = COUNT_W + 1;
    localparam int TOTAL = axis_total(VISIBLE, FP, SYNC, BP);

    localparam logic [XW-1:0] LAST     = XW'(TOTAL - 1);
    localparam logic [XW-1:0] VIS_END  = XW'(VISIBLE);
    localparam logic [XW-1:0] SYNC_BEG = XW'(VISIBLE + FP);
    localparam logic [XW-1:0] SYNC_END = XW'(VISIBLE + FP + SYNC);

    logic [XW-1:0] pos_x;

    assign pos_x   = {1'b0, pos};
    assign wrap    = step && (pos_x == LAST);
    assign active  = pos_x < VIS_END;
    assign sync_on = (pos_x >= SYNC_BEG) && (pos_x < SYNC_END);

    // Position register: advance on step, wrap to zero after the last position.
    always_ff @(posedge clk) begin
        if (rst)       pos <= '0;
        else if (step) pos <= wrap ? '0 : pos + 1'b1;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing generator. A clock-enable divider
// produces one pix_en per CLK_DIV clocks; hcount/vcount advance on it and the
// registered sync/de/colour outputs lag the counters by exactly one pixel.
// Optional build macro VGA_TEST_PATTERN_EN adds pattern_sel and a scrolling
// gradient test pattern driven by an 8-bit frame counter.
module vga_timing_gen #(
    parameter int CLK_DIV   = 3,
    parameter int COUNT_W   = 12,
    parameter int COLOR_W   = 4,
    parameter int H_VISIBLE = 800,
    parameter int H_FP      = 40,
    parameter int H_SYNC    = 128,
    parameter int H_BP      = 88,
    parameter int V_VISIBLE = 600,
    parameter int V_FP      = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BP      = 23,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                 pattern_sel,
`endif
    input  logic [3*COLOR_W-1:0] rgb_in,
    output logic                 pix_en,
    output logic [COUNT_W-1:0]   hcount,
    output logic [COUNT_W-1:0]   vcount,
    output logic                 line_start,
    output logic                 frame_start,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 de,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue
);
    import vga_pkg::*;

    localparam int     H_TOTAL     = axis_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
    localparam int     V_TOTAL     = axis_total(V_VISIBLE, V_FP, V_SYNC, V_BP);
    localparam longint COUNT_RANGE = longint'(1) << COUNT_W;
    localparam int     TICK_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end
    if (longint'(H_TOTAL) > COUNT_RANGE) begin : g_bad_h
        $error("vga_timing_gen: H_TOTAL does not fit in COUNT_W bits");
    end
    if (longint'(V_TOTAL) > COUNT_RANGE) begin : g_bad_v
        $error("vga_timing_gen: V_TOTAL does not fit in COUNT_W bits");
    end

    logic [TICK_W-1:0]    tick;
    logic                 advance;
    logic                 running;
    logic                 step_h;
    logic                 out_en;
    logic                 h_wrap, v_wrap;
    logic                 h_active, v_active, visible;
    logic                 h_sync_on, v_sync_on;
    logic [3*COLOR_W-1:0] pix_rgb;

    // advance marks the clock that starts a pixel period. The first one after
    // reset only announces (0,0); counting and output updates start after it.
    assign advance = (tick == TICK_LAST);
    assign step_h  = advance && running;
    assign out_en  = advance && running;
    assign visible = h_active && v_active;

    // Divider: tick runs 0..CLK_DIV-1 and wraps.
    always_ff @(posedge clk) begin
        if (rst) tick <= '0;
        else     tick <= advance ? '0 : tick + 1'b1;
    end

    // Pixel-rate pulses, registered alongside the counter update.
    always_ff @(posedge clk) begin
        if (rst) begin
            running     <= 1'b0;
            pix_en      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_en      <= advance;
            line_start  <= advance && (!running || h_wrap);
            frame_start <= advance && (!running || v_wrap);
            if (advance) running <= 1'b1;
        end
    end

    vga_axis_counter #(
        .COUNT_W(COUNT_W), .VISIBLE(H_VISIBLE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
    ) u_h (
        .clk(clk), .rst(rst), .step(step_h), .pos(hcount),
        .wrap(h_wrap), .active(h_active), .sync_on(h_sync_on)
    );

    // Lines advance only on the horizontal wrap, so v_wrap implies h_wrap.
    vga_axis_counter #(
        .COUNT_W(COUNT_W), .VISIBLE(V_VISIBLE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
    ) u_v (
        .clk(clk), .rst(rst), .step(h_wrap), .pos(vcount),
        .wrap(v_wrap), .active(v_active), .sync_on(v_sync_on)
    );

`ifdef VGA_TEST_PATTERN_EN
    logic [7:0]         frame_cnt;
    logic [3:0]         ramp;
    logic [COLOR_W-1:0] level;

    if (COUNT_W < 9) begin : g_bad_pat
        $error("vga_timing_gen: test pattern needs COUNT_W >= 9");
    end

    // Frame counter scrolls the bars; cleared by reset so restarts repeat exactly.
    always_ff @(posedge clk) begin
        if (rst)              frame_cnt <= '0;
        else if (frame_start) frame_cnt <= frame_cnt + 8'd1;
    end

    assign ramp    = hcount[8:5] + frame_cnt[5:2];
    assign level   = COLOR_W'(ramp);
    assign pix_rgb = pattern_sel ? {{COLOR_W{vcount[8]}} & level,
                                    {COLOR_W{vcount[7]}} & level,
                                    {COLOR_W{vcount[6]}} & level} : rgb_in;
`else
    assign pix_rgb = rgb_in;
`endif

    // Output stage: capture the pixel that sat on hcount/vcount for the whole
    // previous period, together with its colour, at the start of the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            de    <= 1'b0;
            red   <= '0;
            green <= '0;
            blue  <= '0;
            hsync <= ~HSYNC_POL;
            vsync <= ~VSYNC_POL;
        end else if (out_en) begin
            de                 <= visible;
            {red, green, blue} <= visible ? pix_rgb : '0;
            hsync              <= h_sync_on ~^ HSYNC_POL;
            vsync              <= v_sync_on ~^ VSYNC_POL;
        end
    end

endmodule
